// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame FSM states, frame/packet sizes and mouse byte-0 bit positions.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS  = 11;
  localparam int unsigned MOUSE_PKT_BYTES = 3;

  localparam int unsigned B0_BTN_L  = 0;
  localparam int unsigned B0_BTN_R  = 1;
  localparam int unsigned B0_BTN_M  = 2;
  localparam int unsigned B0_SYNC   = 3;
  localparam int unsigned B0_X_SIGN = 4;
  localparam int unsigned B0_Y_SIGN = 5;
  localparam int unsigned B0_X_OVF  = 6;
  localparam int unsigned B0_Y_OVF  = 7;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_frame_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronisers, PS2C glitch filter, 11-bit frame FSM and idle timeout.
// Parity is enforced only when PS2_MOUSE_PARITY_CHECK_EN is defined.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       byte_err_o,
  output logic       abort_o
);

  localparam int unsigned FltW     = $clog2(FILTER);
  localparam int unsigned TmoW     = $clog2(TIMEOUT + 1);
  localparam int unsigned DataBits = PS2_FRAME_BITS - 3;

  logic             c_meta_q, c_sync_q, d_meta_q, d_sync_q;
  logic             filt_q, filt_d;
  logic [FltW-1:0]  flt_cnt_q, flt_cnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  ps2_frame_state_e state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_err_q, byte_err_d;
  logic             edge_seen, fall, abort, par_ok;

  always_comb begin
    // Level only moves after FILTER consecutive samples disagree with it.
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (c_sync_q != filt_q) begin
      if (flt_cnt_q == FltW'(FILTER - 1)) begin
        filt_d = c_sync_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
    edge_seen = (filt_d != filt_q);
    fall      = edge_seen & ~filt_d;

    // Saturating idle counter; a filtered edge always wins over the timeout.
    tmo_d = tmo_q;
    abort = 1'b0;
    if (edge_seen) begin
      tmo_d = '0;
    end else if (tmo_q != TmoW'(TIMEOUT)) begin
      tmo_d = tmo_q + 1'b1;
      abort = (tmo_q == TmoW'(TIMEOUT - 1));
    end
  end

`ifdef PS2_MOUSE_PARITY_CHECK_EN
  assign par_ok = par_q;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!d_sync_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
            par_d     = 1'b0;
          end
        end
        StData: begin
          shift_d = {d_sync_q, shift_q[7:1]};
          par_d   = par_q ^ d_sync_q;
          if (bit_cnt_q == 3'(DataBits - 1)) begin
            state_d = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StParity: begin
          par_d   = par_q ^ d_sync_q;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (d_sync_q && par_ok) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            byte_err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_meta_q     <= 1'b1;
      c_sync_q     <= 1'b1;
      d_meta_q     <= 1'b1;
      d_sync_q     <= 1'b1;
      filt_q       <= 1'b1;
      flt_cnt_q    <= '0;
      tmo_q        <= '0;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      c_meta_q     <= ps2c_i;
      c_sync_q     <= c_meta_q;
      d_meta_q     <= ps2d_i;
      d_sync_q     <= d_meta_q;
      filt_q       <= filt_d;
      flt_cnt_q    <= flt_cnt_d;
      tmo_q        <= tmo_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      byte_err_q   <= byte_err_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign byte_err_o   = byte_err_q;
  assign abort_o      = abort;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse cursor tracker: assembles 3-byte movement packets and keeps a clamped x/y and buttons.
// Define PS2_MOUSE_PARITY_CHECK_EN to treat parity mismatches as frame errors.
module ps2_mouse_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 8,
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MAX   = 239,
  parameter int unsigned X_INIT  = 320,
  parameter int unsigned Y_INIT  = 120,
  parameter int unsigned SHIFT   = 0,
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           PS2C,
  input  logic           PS2D,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           btnl,
  output logic           btnr,
  output logic           btnm,
  output logic           pkt_valid,
  output logic           err,
  output logic [7:0]     led
);

  localparam int unsigned W = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam logic signed [W-1:0] XMaxS = W'(X_MAX);
  localparam logic signed [W-1:0] YMaxS = W'(Y_MAX);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err, rx_abort;

  ps2_rx #(
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT)
  ) u_rx (
    .clk_i       (clk),
    .rst_i       (rst),
    .ps2c_i      (PS2C),
    .ps2d_i      (PS2D),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .byte_err_o  (rx_err),
    .abort_o     (rx_abort)
  );

  logic [1:0]      idx_q, idx_d;
  logic [7:0]      b0_q, b0_d;
  logic [7:0]      dx_byte_q, dx_byte_d;
  logic [X_W-1:0]  x_q, x_d, x_new;
  logic [Y_W-1:0]  y_q, y_d, y_new;
  logic [2:0]      btn_q, btn_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            sync_err;
  logic [8:0]      dx9, dy9;
  logic signed [W-1:0] dx_ext, dy_ext, dx_sh, dy_sh, x_sum, y_sum;

  always_comb begin
    // Byte 2 is still on rx_byte while byte_valid is high, so dy comes straight from it.
    dx9    = {b0_q[B0_X_SIGN], dx_byte_q};
    dy9    = {b0_q[B0_Y_SIGN], rx_byte};
    dx_ext = b0_q[B0_X_OVF] ? '0 : {{(W - 9){dx9[8]}}, dx9};
    dy_ext = b0_q[B0_Y_OVF] ? '0 : {{(W - 9){dy9[8]}}, dy9};
    dx_sh  = dx_ext >>> SHIFT;
    dy_sh  = dy_ext >>> SHIFT;
    x_sum  = $signed({{(W - X_W){1'b0}}, x_q}) + dx_sh;
    y_sum  = $signed({{(W - Y_W){1'b0}}, y_q}) - dy_sh;

    if (x_sum < 0)          x_new = '0;
    else if (x_sum > XMaxS) x_new = X_W'(X_MAX);
    else                    x_new = x_sum[X_W-1:0];

    if (y_sum < 0)          y_new = '0;
    else if (y_sum > YMaxS) y_new = Y_W'(Y_MAX);
    else                    y_new = y_sum[Y_W-1:0];
  end

  assign sync_err = rx_valid && (idx_q == 2'd0) && !rx_byte[B0_SYNC];

  always_comb begin
    idx_d       = idx_q;
    b0_d        = b0_q;
    dx_byte_d   = dx_byte_q;
    x_d         = x_q;
    y_d         = y_q;
    btn_d       = btn_q;
    pkt_valid_d = 1'b0;
    if (rx_abort || rx_err) begin
      idx_d = '0;
    end else if (rx_valid) begin
      if (idx_q == 2'd0) begin
        if (rx_byte[B0_SYNC]) begin
          b0_d  = rx_byte;
          idx_d = 2'd1;
        end
      end else if (idx_q != 2'(MOUSE_PKT_BYTES - 1)) begin
        dx_byte_d = rx_byte;
        idx_d     = idx_q + 1'b1;
      end else begin
        x_d         = x_new;
        y_d         = y_new;
        btn_d       = {b0_q[B0_BTN_M], b0_q[B0_BTN_R], b0_q[B0_BTN_L]};
        pkt_valid_d = 1'b1;
        idx_d       = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      b0_q        <= '0;
      dx_byte_q   <= '0;
      x_q         <= X_W'(X_INIT);
      y_q         <= Y_W'(Y_INIT);
      btn_q       <= '0;
      pkt_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      b0_q        <= b0_d;
      dx_byte_q   <= dx_byte_d;
      x_q         <= x_d;
      y_q         <= y_d;
      btn_q       <= btn_d;
      pkt_valid_q <= pkt_valid_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign btnl      = btn_q[0];
  assign btnr      = btn_q[1];
  assign btnm      = btn_q[2];
  assign pkt_valid = pkt_valid_q;
  assign err       = rx_err | sync_err;
  assign led       = rx_byte;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: table vectors, corner sequences and random packets
// against a byte-stream reference model; a second instance runs with SHIFT = 1.
module tb_ps2_mouse_tracker;

  localparam int Tmo  = 4000;
  localparam int Filt = 8;
`ifdef PS2_MOUSE_PARITY_CHECK_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic PS2C = 1'b1;
  logic PS2D = 1'b1;
  logic [9:0] x0, x1;
  logic [7:0] y0, y1, led0, led1;
  logic btnl0, btnr0, btnm0, btnl1, btnr1, btnm1;
  logic pv0, pv1, err0, err1;

  always #5 clk = ~clk;

  ps2_mouse_tracker #(.SHIFT(0), .FILTER(Filt), .TIMEOUT(Tmo)) u_dut (
    .clk(clk), .rst(rst), .PS2C(PS2C), .PS2D(PS2D), .x(x0), .y(y0), .btnl(btnl0),
    .btnr(btnr0), .btnm(btnm0), .pkt_valid(pv0), .err(err0), .led(led0)
  );

  ps2_mouse_tracker #(.SHIFT(1), .FILTER(Filt), .TIMEOUT(Tmo)) u_dut_s1 (
    .clk(clk), .rst(rst), .PS2C(PS2C), .PS2D(PS2D), .x(x1), .y(y1), .btnl(btnl1),
    .btnr(btnr1), .btnm(btnm1), .pkt_valid(pv1), .err(err1), .led(led1)
  );

  int pkt_cnt0 = 0, pkt_cnt1 = 0, err_cnt0 = 0, err_cnt1 = 0;
  always @(negedge clk) begin
    if (pv0)  pkt_cnt0 <= pkt_cnt0 + 1;
    if (pv1)  pkt_cnt1 <= pkt_cnt1 + 1;
    if (err0) err_cnt0 <= err_cnt0 + 1;
    if (err1) err_cnt1 <= err_cnt1 + 1;
  end

  // Reference model: byte stream in, packet-level cursor state out.
  int m_x[2], m_y[2];
  int m_btn, m_idx, m_b0, m_b1, m_pkt, m_err, m_led;

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_x[s] = 320;
      m_y[s] = 120;
    end
    m_btn = 0;
    m_idx = 0;
    m_led = 0;
  endfunction

  function automatic void model_byte(input int data, input bit bad_par, input bit bad_stop);
    int dx, dy;
    if (bad_stop || (bad_par && ParEn)) begin
      m_err++;
      m_idx = 0;
      return;
    end
    m_led = data;
    if (m_idx == 0) begin
      if (data[3] == 1'b0) m_err++;
      else begin
        m_b0  = data;
        m_idx = 1;
      end
    end else if (m_idx == 1) begin
      m_b1  = data;
      m_idx = 2;
    end else begin
      dx = m_b0[6] ? 0 : (m_b0[4] ? m_b1 - 256 : m_b1);
      dy = m_b0[7] ? 0 : (m_b0[5] ? data - 256 : data);
      for (int s = 0; s < 2; s++) begin
        m_x[s] = clampi(m_x[s] + (dx >>> s), 639);
        m_y[s] = clampi(m_y[s] - (dy >>> s), 239);
      end
      m_btn = {m_b0[2], m_b0[1], m_b0[0]};
      m_pkt++;
      m_idx = 0;
    end
  endfunction

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " x"}, int'(x0), m_x[0]);
    chk({tag, " y"}, int'(y0), m_y[0]);
    chk({tag, " btn"}, int'({btnm0, btnr0, btnl0}), m_btn);
    chk({tag, " x_s1"}, int'(x1), m_x[1]);
    chk({tag, " y_s1"}, int'(y1), m_y[1]);
    chk({tag, " btn_s1"}, int'({btnm1, btnr1, btnl1}), m_btn);
    chk({tag, " pkt_cnt"}, pkt_cnt0, m_pkt);
    chk({tag, " pkt_cnt_s1"}, pkt_cnt1, m_pkt);
    chk({tag, " err_cnt"}, err_cnt0, m_err);
    chk({tag, " err_cnt_s1"}, err_cnt1, m_err);
    chk({tag, " led"}, int'(led0), m_led);
    chk({tag, " led_s1"}, int'(led1), m_led);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_n(3);
    rst = 1'b0;
    wait_n(2);
    model_reset();
  endtask

  // One 40-clk bit; a glitch drops PS2C for Filt-1 cycles inside the high phase.
  task automatic send_bit(input bit b, input bit glitch);
    PS2D = b;
    if (glitch) begin
      wait_n(2);
      PS2C = 1'b0;
      wait_n(Filt - 1);
      PS2C = 1'b1;
      wait_n(1);
    end else begin
      wait_n(10);
    end
    PS2C = 1'b0;
    wait_n(20);
    PS2C = 1'b1;
    wait_n(10);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                            input int glitch_at);
    logic [10:0] bits;
    bits = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch_at == i);
    PS2D = 1'b1;
    wait_n(40);
    model_byte(int'(data), bad_par, bad_stop);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0, 1'b0, -1);
    send_frame(b1, 1'b0, 1'b0, -1);
    send_frame(b2, 1'b0, 1'b0, -1);
  endtask

  typedef struct {
    bit         do_rst;
    logic [7:0] b0, b1, b2;
    int         ex, ey, ebtn;
  } vec_t;

  vec_t tbl[10];
  logic [7:0] rb0, rb1, rb2;

  initial begin
    tbl[0] = '{1'b1, 8'h09, 8'h05, 8'h03, 325, 117, 1};
    tbl[1] = '{1'b1, 8'h18, 8'h00, 8'h00, 64, 120, 0};
    tbl[2] = '{1'b0, 8'h18, 8'h00, 8'h00, 0, 120, 0};
    tbl[3] = '{1'b0, 8'h08, 8'hFF, 8'h80, 255, 0, 0};
    tbl[4] = '{1'b0, 8'h08, 8'hFF, 8'h80, 510, 0, 0};
    tbl[5] = '{1'b0, 8'h08, 8'hFF, 8'h80, 639, 0, 0};
    tbl[6] = '{1'b0, 8'h0E, 8'h00, 8'h00, 639, 0, 6};
    tbl[7] = '{1'b0, 8'h28, 8'h00, 8'h01, 639, 239, 0};
    tbl[8] = '{1'b0, 8'h48, 8'h7F, 8'h00, 639, 239, 0};
    tbl[9] = '{1'b0, 8'h98, 8'h10, 8'h50, 399, 239, 0};
    m_pkt = 0;
    m_err = 0;
    m_b0  = 0;
    m_b1  = 0;

    do_reset();
    wait_n(1000);
    check_all("idle");

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].do_rst) do_reset();
      send_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2);
      chk($sformatf("tbl%0d x", i), int'(x0), tbl[i].ex);
      chk($sformatf("tbl%0d y", i), int'(y0), tbl[i].ey);
      chk($sformatf("tbl%0d btn", i), int'({btnm0, btnr0, btnl0}), tbl[i].ebtn);
      check_all($sformatf("tbl%0d", i));
    end

    do_reset();
    send_pkt(8'h09, 8'h05, 8'h03);
    chk("shift1 x", int'(x1), 322);
    chk("shift1 y", int'(y1), 119);
    check_all("shift");

    send_frame(8'h09, 1'b0, 1'b0, -1);
    send_frame(8'h05, 1'b1, 1'b0, -1);
    send_pkt(8'h09, 8'h05, 8'h03);
    check_all("badpar");

    send_frame(8'h00, 1'b0, 1'b0, -1);
    send_pkt(8'h09, 8'h05, 8'h03);
    check_all("sync");

    send_frame(8'h55, 1'b0, 1'b1, -1);
    check_all("stop0");

    send_frame(8'h09, 1'b0, 1'b0, -1);
    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 1'b0);
    PS2D = 1'b1;
    wait_n(Tmo + 10);
    m_idx = 0;
    send_pkt(8'h19, 8'hF0, 8'h08);
    check_all("timeout");

    send_frame(8'h0A, 1'b0, 1'b0, -1);
    send_frame(8'h21, 1'b0, 1'b0, 4);
    send_frame(8'h11, 1'b0, 1'b0, 7);
    check_all("glitch");

    send_frame(8'h08, 1'b0, 1'b0, -1);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    PS2D = 1'b1;
    do_reset();
    send_pkt(8'h09, 8'h05, 8'h03);
    check_all("rst_mid");

    for (int i = 0; i < 12; i++) begin
      rb0 = 8'($urandom_range(0, 255));
      rb1 = 8'($urandom_range(0, 255));
      rb2 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) rb0[3] = 1'b1;
      send_pkt(rb0, rb1, rb2);
      check_all($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
